// File: rtl/spec_rotator_pkg.sv
// Spectrum rotator shared types: mode encodings and
// the per-rotation swap/negate table.
package spec_rot_pkg;

  typedef enum logic [1:0] {
    MODE_BYP = 2'd0,
    MODE_P4  = 2'd1,
    MODE_H2  = 2'd2,
    MODE_M4  = 2'd3
  } mode_e;

  typedef struct packed {
    logic swap;
    logic neg_i;
    logic neg_q;
  } rot_t;

  function automatic logic [1:0] rot_idx(
    input logic [1:0] p,
    input logic [1:0] m
  );
    logic [3:0] prod;
    prod = {2'b00, p} * {2'b00, m};
    return prod[1:0];
  endfunction

  // j^r applied to (i,q): which rails swap and which get negated
  function automatic rot_t rot_lut(input logic [1:0] r);
    rot_t t;
    t = '0;
    unique case (r)
      2'd0: t = '{swap: 1'b0, neg_i: 1'b0, neg_q: 1'b0};
      2'd1: t = '{swap: 1'b1, neg_i: 1'b1, neg_q: 1'b0};
      2'd2: t = '{swap: 1'b0, neg_i: 1'b1, neg_q: 1'b1};
      2'd3: t = '{swap: 1'b1, neg_i: 1'b0, neg_q: 1'b1};
      default: t = '0;
    endcase
    return t;
  endfunction

endpackage

// File: rtl/spec_rotator_if.sv
// Sample stream into and out of the spectrum rotator.
// master drives samples, slave is the rotator.
interface spec_rotator_if #(
  parameter int W = 16
);
  logic                en;
  logic                in_sop;
  logic [1:0]          mode;
  logic signed [W-1:0] in_i;
  logic signed [W-1:0] in_q;
  logic signed [W-1:0] out_i;
  logic signed [W-1:0] out_q;
  logic                out_valid;
  logic                sop_out;
  logic                sat_flag;

  modport master (
    output en,
    output in_sop,
    output mode,
    output in_i,
    output in_q,
    input  out_i,
    input  out_q,
    input  out_valid,
    input  sop_out,
    input  sat_flag
  );

  modport slave (
    input  en,
    input  in_sop,
    input  mode,
    input  in_i,
    input  in_q,
    output out_i,
    output out_q,
    output out_valid,
    output sop_out,
    output sat_flag
  );

endinterface

// File: rtl/spec_rotator_sat_neg.sv
// Conditional two's complement negate that clips
// the most negative value to the most positive one.
module sat_neg #(
  parameter int W = 16
) (
  input  logic signed [W-1:0] a,
  input  logic                neg,
  output logic signed [W-1:0] y,
  output logic                clip
);

  localparam logic signed [W-1:0] MIN =
    {1'b1, {(W-1){1'b0}}};
  localparam logic signed [W-1:0] MAX =
    {1'b0, {(W-1){1'b1}}};

  always_comb begin
    clip = neg && (a == MIN);
    y    = a;
    if (neg) begin
      y = clip ? MAX : -a;
    end
  end

endmodule

// File: rtl/spec_rotator.sv
// Multiplies each valid I/Q sample by j^(p*mode),
// phase aligned to symbol start, 2-cycle pipeline.
module spec_rotator
  import spec_rot_pkg::*;
#(
  parameter int W         = 16,
  parameter bit SOP_ALIGN = 1'b1
) (
  input logic           clk,
  input logic           rst,
  spec_rotator_if.slave bus
);

  logic [1:0] p;
  logic [1:0] mode_r;
  logic [1:0] p_use;
  logic [1:0] mode_use;
  logic [1:0] r;
  logic       sop_hit;
  rot_t       rt;

  logic signed [W-1:0] s1_i;
  logic signed [W-1:0] s1_q;
  logic                s1_ni;
  logic                s1_nq;
  logic                v1;
  logic                sop1;

  logic signed [W-1:0] n_i;
  logic signed [W-1:0] n_q;
  logic                c_i;
  logic                c_q;

  // sop restarts the phase and latches the mode for the symbol
  always_comb begin
    sop_hit  = SOP_ALIGN && bus.in_sop;
    p_use    = sop_hit ? 2'd0 : p;
    mode_use = mode_r;
    if (sop_hit || !SOP_ALIGN) begin
      mode_use = bus.mode;
    end
    r  = rot_idx(p_use, mode_use);
    rt = rot_lut(r);
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      p      <= 2'd0;
      mode_r <= MODE_BYP;
    end else if (bus.en) begin
      p      <= p_use + 2'd1;
      mode_r <= mode_use;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      s1_i  <= '0;
      s1_q  <= '0;
      s1_ni <= 1'b0;
      s1_nq <= 1'b0;
      v1    <= 1'b0;
      sop1  <= 1'b0;
    end else begin
      v1   <= bus.en;
      sop1 <= bus.en && bus.in_sop;
      if (bus.en) begin
        s1_i  <= rt.swap ? bus.in_q : bus.in_i;
        s1_q  <= rt.swap ? bus.in_i : bus.in_q;
        s1_ni <= rt.neg_i;
        s1_nq <= rt.neg_q;
      end
    end
  end

  sat_neg #(
    .W (W)
  ) u_neg_i (
    .a    (s1_i),
    .neg  (s1_ni),
    .y    (n_i),
    .clip (c_i)
  );

  sat_neg #(
    .W (W)
  ) u_neg_q (
    .a    (s1_q),
    .neg  (s1_nq),
    .y    (n_q),
    .clip (c_q)
  );

  // data holds across bubbles; flags only mark real samples
  always_ff @(posedge clk) begin
    if (!rst) begin
      bus.out_i     <= '0;
      bus.out_q     <= '0;
      bus.out_valid <= 1'b0;
      bus.sop_out   <= 1'b0;
      bus.sat_flag  <= 1'b0;
    end else begin
      bus.out_valid <= v1;
      bus.sop_out   <= v1 && sop1;
      bus.sat_flag  <= v1 && (c_i || c_q);
      if (v1) begin
        bus.out_i <= n_i;
        bus.out_q <= n_q;
      end
    end
  end

endmodule
